byte_packer: RTL and testbench
==============================

BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 Parameter FLUSH_TIMEOUT, default 16: idle cycles before a partial word is flushed; 0 disables flushing.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_valid  input  1  upstream byte valid.
REQ-005 o_ready  output  1  ready to upstream; byte accepted when i_valid && o_ready at a clk edge.
REQ-006 i_data  input  8  upstream byte.
REQ-007 i_last  input  1  byte is final of packet; qualified by i_valid.
REQ-008 o_valid  output  1  packed word valid to downstream.
REQ-009 i_ready  input  1  downstream ready; word transferred when o_valid && i_ready at a clk edge.
REQ-010 o_data  output  32  packed word, first-accepted byte in [7:0], little-endian.
REQ-011 o_keep  output  4  byte-lane enables for o_data; bit n covers o_data[8n+7:8n].
REQ-012 o_last  output  1  word ends a packet.

Function
REQ-013 Internal state: 24-bit accumulator, 2-bit byte count cnt (0..3), output register {o_data, o_keep, o_last, o_valid}, idle counter.
REQ-014 out_free = !o_valid || i_ready; o_ready = out_free (combinational path from i_ready to o_ready is required).
REQ-015 Accepted byte with cnt<3 and i_last=0: byte stored in lane cnt of accumulator, cnt increments, no output load.
REQ-016 Accepted byte with cnt==3 or i_last=1: output register loads accumulator lanes 0..cnt-1 plus new byte in lane cnt, o_keep = (1<<(cnt+1))-1, o_last = i_last, o_valid = 1; cnt clears to 0.
REQ-017 Unused lanes of o_data (o_keep bit 0) shall be driven 0.
REQ-018 Latency: word visible on o_data/o_valid the cycle after the completing byte is accepted.
REQ-019 Throughput: one byte per cycle sustained while i_ready=1; back-to-back words with no bubble.
REQ-020 o_valid, o_data, o_keep, o_last shall hold stable while o_valid && !i_ready.
REQ-021 o_valid clears after a transfer unless a new word loads in the same cycle; load and drain in the same cycle shall yield the new word.
REQ-022 Idle counter: cleared on every accepted byte or when cnt==0; otherwise increments, saturating at FLUSH_TIMEOUT.
REQ-023 Flush: when FLUSH_TIMEOUT>0, cnt>0, idle counter == FLUSH_TIMEOUT, no byte accepted this cycle, and out_free: output loads the partial word with o_keep = (1<<cnt)-1, o_last = 0; cnt and idle counter clear.
REQ-024 Flush blocked by !out_free shall stay pending (counter saturated) and fire the first cycle out_free=1.
REQ-025 A byte accepted in the same cycle the timeout would expire takes precedence; no flush, normal REQ-015/016 handling.
REQ-026 i_data/i_last ignored when i_valid=0; a packet shall never mix bytes across an i_last boundary.

Reset
REQ-027 On reset: o_valid=0, o_data=0, o_keep=0, o_last=0, cnt=0, accumulator=0, idle counter=0; o_ready follows REQ-014 (=1).
REQ-028 Reset asserted mid-packet or with o_valid=1 discards all held bytes and the pending word; no output transfer occurs in the reset cycle.

Verification
REQ-029 Stream 8'h6F,8'h70,8'h74,8'h65 (i_last on 4th), i_ready=1 -> one word o_data=32'h6574706F, o_keep=4'hF, o_last=1, one cycle after 4th byte.
REQ-030 Packet 8'h11,8'h22,8'h33 with i_last on 3rd -> o_data=32'h00332211, o_keep=4'h7, o_last=1.
REQ-031 Word pending, i_ready=0 for 3 cycles with i_valid=1 -> o_ready=0, output held stable, no byte lost; release i_ready -> transfer, then bytes resume with no gap.
REQ-032 FLUSH_TIMEOUT=4, single byte 8'hAB then idle -> after 4 idle cycles o_data=32'h000000AB, o_keep=4'h1, o_last=0; a byte arriving on the expiry cycle suppresses the flush.
REQ-033 8 continuous bytes 8'h01..8'h08, i_ready=1 -> words 32'h04030201 then 32'h08070605 on consecutive transfers, o_ready never low.
REQ-034 Reset asserted after 2 bytes of a packet -> o_valid=0, next 4 bytes form a clean word with no residue.

Source files
------------

// File: rtl/byte_packer_if.sv
// Byte-in / word-out stream signals of byte_packer, grouped for port binding.
// The slave modport is the packer's side; master is the environment driving it.
interface byte_packer_if;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_data;
    logic        i_last;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic [3:0]  o_keep;
    logic        o_last;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_last,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_data,
        output o_keep,
        output o_last
    );

    modport master (
        output i_valid,
        output i_data,
        output i_last,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_data,
        input  o_keep,
        input  o_last
    );
endinterface

// File: rtl/byte_packer.sv
// Packs a byte stream into little-endian 32-bit words with lane keeps; partial
// words close on i_last, or are flushed after FLUSH_TIMEOUT idle cycles.
module byte_packer #(
    parameter int unsigned FLUSH_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    byte_packer_if.slave  bus
);
    localparam int unsigned IW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] IDLE_MAX = IW'(FLUSH_TIMEOUT);

    logic [23:0]   acc;
    logic [1:0]    cnt;
    logic [IW-1:0] idle;

    logic [31:0] data_q;
    logic [3:0]  keep_q;
    logic        last_q;
    logic        valid_q;

    logic        out_free;
    logic        accept;
    logic        complete;
    logic        flush;
    logic [3:0]  keep_part;
    logic [3:0]  keep_full;
    logic [31:0] word_part;
    logic [31:0] word_full;
    logic [2:0]  cnt_inc;

    assign out_free    = !valid_q || bus.i_ready;
    assign bus.o_ready = out_free;
    assign accept      = bus.i_valid && out_free;
    assign complete    = accept && ((cnt == 2'd3) || bus.i_last);
    assign flush       = (FLUSH_TIMEOUT != 0) && (cnt != 2'd0) && (idle == IDLE_MAX)
                         && !accept && out_free;

    assign cnt_inc   = {1'b0, cnt} + 3'd1;
    assign keep_part = 4'((5'd1 << cnt) - 5'd1);
    assign keep_full = 4'((5'd1 << cnt_inc) - 5'd1);

    // Lanes at or above cnt are masked so stale accumulator bits never leak out.
    always_comb begin
        word_part = {8'h00, acc & {{8{keep_part[2]}}, {8{keep_part[1]}}, {8{keep_part[0]}}}};
        word_full = word_part;
        case (cnt)
            2'd0:    word_full[7:0]   = bus.i_data;
            2'd1:    word_full[15:8]  = bus.i_data;
            2'd2:    word_full[23:16] = bus.i_data;
            default: word_full[31:24] = bus.i_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (complete || flush) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            case (cnt)
                2'd0:    acc[7:0]   <= bus.i_data;
                2'd1:    acc[15:8]  <= bus.i_data;
                default: acc[23:16] <= bus.i_data;
            endcase
            cnt <= cnt + 2'd1;
        end
    end

    // Saturates at IDLE_MAX, so a flush held off by backpressure stays armed.
    always_ff @(posedge clk) begin
        if (reset || accept || flush || (cnt == 2'd0)) begin
            idle <= '0;
        end else if (idle != IDLE_MAX) begin
            idle <= idle + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (complete) begin
            data_q  <= word_full;
            keep_q  <= keep_full;
            last_q  <= bus.i_last;
            valid_q <= 1'b1;
        end else if (flush) begin
            data_q  <= word_part;
            keep_q  <= keep_part;
            last_q  <= 1'b0;
            valid_q <= 1'b1;
        end else if (bus.i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_keep  = keep_q;
    assign bus.o_last  = last_q;
endmodule

// File: tb/tb_byte_packer.sv
// Scoreboard bench for byte_packer: a byte-level model queues expected words,
// a negedge monitor pops and compares each transferred word.
module tb_byte_packer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    byte_packer_if bus ();

    byte_packer #(.FLUSH_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    word_t       sb_q[$];
    logic [31:0] m_data;
    int unsigned m_n;

    int checks = 0;
    int failures = 0;
    int stall_cycles = 0;
    int n_pushed = 0;
    int n_popped = 0;
    int n_dropped = 0;
    bit ready_ctl = 1'b1;
    bit rnd_ready = 1'b0;
    bit ready_watch = 1'b0;
    bit ready_low = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_push(input logic last);
        word_t w;
        w.data = m_data;
        w.keep = 4'((1 << m_n) - 1);
        w.last = last;
        sb_q.push_back(w);
        n_pushed++;
        m_data = '0;
        m_n = 0;
    endtask

    task automatic model_clear();
        m_data = '0;
        m_n = 0;
        n_dropped += sb_q.size();
        sb_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        bit accepted = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_last  = last;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.o_ready) begin
                accepted = 1'b1;
                break;
            end
            stall_cycles++;
        end
        check_val("accept_timeout", accepted, 1);
        if (accepted) begin
            m_data[8*m_n +: 8] = d;
            m_n++;
            if (last || m_n == 4) model_push(last);
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'($urandom);
        bus.i_last  = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        bus.i_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_ctl;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (ready_watch && !bus.o_ready) ready_low = 1'b1;
            if (bus.o_valid && bus.i_ready) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_word", sb_q.size(), 1);
                end else begin
                    check_val("word", {bus.o_data, bus.o_keep, bus.o_last}, sb_q.pop_front());
                    n_popped++;
                end
            end
        end
    end

    initial begin
        int st0;
        int k;
        int len;
        m_data = '0;
        m_n = 0;
        reset = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        bus.i_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("rst_valid", bus.o_valid, 0);
        check_val("rst_data",  bus.o_data, 0);
        check_val("rst_keep",  bus.o_keep, 0);
        check_val("rst_last",  bus.o_last, 0);
        check_val("rst_ready", bus.o_ready, 1);
        @(posedge clk); #1;

        // Full word, latency one cycle after the completing byte
        send_byte(8'h6F, 0); send_byte(8'h70, 0); send_byte(8'h74, 0); send_byte(8'h65, 1);
        check_val("lat_valid", bus.o_valid, 1);
        check_val("lat_data", bus.o_data, 32'h6574706F);
        repeat (2) @(posedge clk); #1;

        // Short packet
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 1);
        check_val("short_data", bus.o_data, 32'h00332211);
        check_val("short_keep", bus.o_keep, 4'h7);
        repeat (2) @(posedge clk); #1;

        // Sustained stream, ready never drops
        st0 = stall_cycles;
        ready_watch = 1'b1;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        ready_watch = 1'b0;
        check_val("stream_stalls", stall_cycles - st0, 0);
        check_val("stream_ready_low", ready_low, 0);
        repeat (2) @(posedge clk); #1;

        // Backpressure: word held stable, next byte waits exactly 3 cycles
        ready_ctl = 1'b0;
        @(posedge clk); #2;
        send_byte(8'h10, 0); send_byte(8'h20, 0); send_byte(8'h30, 0); send_byte(8'h40, 0);
        st0 = stall_cycles;
        fork
            begin
                send_byte(8'hA1, 0); send_byte(8'hA2, 0); send_byte(8'hA3, 0); send_byte(8'hA4, 1);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    check_val("stall_ready", bus.o_ready, 0);
                    check_val("stall_hold", {bus.o_valid, bus.o_data, bus.o_keep, bus.o_last},
                              {1'b1, 32'h40302010, 4'hF, 1'b0});
                end
                ready_ctl = 1'b1;
            end
        join
        check_val("stall_gap", stall_cycles - st0, 3);
        repeat (2) @(posedge clk); #1;

        // Timeout flush of a single byte
        send_byte(8'hAB, 0);
        model_push(1'b0);
        k = 99;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.o_valid) begin
                k = i;
                break;
            end
        end
        check_val("flush_latency", k, 5);
        check_val("flush_keep", bus.o_keep, 4'h1);
        repeat (2) @(posedge clk); #1;

        // Byte on the expiry cycle suppresses the flush
        send_byte(8'hCD, 0);
        repeat (4) @(posedge clk);
        #1;
        send_byte(8'hEF, 1);
        check_val("suppress_valid", bus.o_valid, 1);
        check_val("suppress_keep", bus.o_keep, 4'h3);
        repeat (2) @(posedge clk); #1;

        // Reset mid-packet
        send_byte(8'h55, 0); send_byte(8'h66, 0);
        reset = 1'b1;
        model_clear();
        @(posedge clk); #1 reset = 1'b0;
        check_val("rst_mid_valid", bus.o_valid, 0);
        send_byte(8'h91, 0); send_byte(8'h92, 0); send_byte(8'h93, 0); send_byte(8'h94, 1);
        check_val("rst_mid_data", bus.o_data, 32'h94939291);
        repeat (2) @(posedge clk); #1;

        // Reset with a word pending under backpressure
        ready_ctl = 1'b0;
        @(posedge clk); #2;
        send_byte(8'h01, 0); send_byte(8'h02, 1);
        check_val("pend_valid", bus.o_valid, 1);
        reset = 1'b1;
        model_clear();
        @(posedge clk); #1 reset = 1'b0;
        ready_ctl = 1'b1;
        check_val("pend_rst_valid", bus.o_valid, 0);
        repeat (2) @(posedge clk); #1;

        // Random packets under random downstream backpressure
        rnd_ready = 1'b1;
        for (int p = 0; p < 20; p++) begin
            len = int'($urandom_range(1, 7));
            for (int b = 0; b < len; b++) send_byte(8'($urandom), b == len - 1);
        end
        rnd_ready = 1'b0;

        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        check_val("sb_drained", sb_q.size(), 0);
        check_val("word_count", n_popped, n_pushed - n_dropped);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
